snoop_bus_ctrl: RTL

- Shared-bus controller for the snooping coherence system.
- Arbitrates NUM_REQ cache controllers for the single shared bus, then runs each bus transaction: broadcast the snoop, collect a dirty-owner intervention, then perform the memory access.
- Sits between the per-processor cache controllers and the tag-addressed memory block; drives that memory's tag and 12-bit bus and reads its 12-bit output.

---
 rtl/snoop_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/snoop_bus_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/snoop_pkg.sv
// Shared types and constants for the snooping shared-bus controller.
package snoop_pkg;

  localparam int TAG_W      = 5;
  localparam int DATA_W     = 8;
  localparam int MEM_BUS_W  = 12;
  localparam int MEM_WR_BIT = 11;

  typedef enum logic [2:0] {
    IDLE,
    BCAST,
    SNOOP,
    MEM,
    RESP
  } bus_state_e;

  typedef struct packed {
    logic              write;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } req_t;

  // Memory bus word that commands a write of d: {write=1, zero pad, data}.
  function automatic logic [MEM_BUS_W-1:0] mem_write_word(input logic [DATA_W-1:0] d);
    logic [MEM_BUS_W-1:0] w;
    w             = '0;
    w[DATA_W-1:0] = d;
    w[MEM_WR_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational bus arbiter: request vector + pointer -> one-hot grant and index.
// Build macro FIXED_PRIORITY_EN selects lowest-index-wins and ignores the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

`ifdef FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
`ifdef FIXED_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
`else
    // Scan from farthest to nearest so the candidate closest to the pointer wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
`endif
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Shared-bus controller: arbitrates cache controllers, broadcasts the snoop,
// collects a dirty-owner intervention, then performs the memory access.
// Build macro FIXED_PRIORITY_EN switches the arbiter to fixed priority.
module snoop_bus_ctrl #(
  parameter int NUM_REQ      = 3,
  parameter int SNOOP_CYCLES = 2,
  parameter int TAG_W        = snoop_pkg::TAG_W,
  parameter int DATA_W       = snoop_pkg::DATA_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      snoop_valid,
  output logic                      snoop_write,
  output logic [TAG_W-1:0]          snoop_tag,
  output logic [NUM_REQ-1:0]        snoop_src,
  input  logic                      snoop_dirty,
  input  logic [DATA_W-1:0]         snoop_data,
  output logic [TAG_W-1:0]          mem_tag_out,
  output logic [11:0]               mem_bus_out,
  input  logic [11:0]               mem_bus_in
);

  import snoop_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(SNOOP_CYCLES + 1);

  bus_state_e           state_q, state_d;
  req_t                 req_q, req_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dirty_q, dirty_d;
  logic [DATA_W-1:0]    sdata_q, sdata_d;

  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]    resp_data_q, resp_data_d;
  logic                 snoop_valid_q, snoop_valid_d;
  logic                 snoop_write_q, snoop_write_d;
  logic [TAG_W-1:0]     snoop_tag_q, snoop_tag_d;
  logic [NUM_REQ-1:0]   snoop_src_q, snoop_src_d;
  logic [TAG_W-1:0]     mem_tag_q, mem_tag_d;
  logic [MEM_BUS_W-1:0] mem_bus_q, mem_bus_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;

  logic [TAG_W-1:0]     tag_arr  [NUM_REQ];
  logic [DATA_W-1:0]    data_arr [NUM_REQ];

  logic unused_mem_hi;
  assign unused_mem_hi = ^mem_bus_in[MEM_BUS_W-1:DATA_W];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign tag_arr[g]  = req_tag[g*TAG_W +: TAG_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Outputs are registered on the edge that enters the state they belong to.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    idx_d         = idx_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    dirty_d       = dirty_q;
    sdata_d       = sdata_q;
    grant_d       = grant_q;
    resp_valid_d  = '0;
    resp_data_d   = resp_data_q;
    snoop_valid_d = 1'b0;
    snoop_write_d = snoop_write_q;
    snoop_tag_d   = snoop_tag_q;
    snoop_src_d   = snoop_src_q;
    mem_tag_d     = mem_tag_q;
    mem_bus_d     = mem_bus_q;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          req_d.write   = req_write[arb_idx];
          req_d.tag     = tag_arr[arb_idx];
          req_d.data    = data_arr[arb_idx];
          idx_d         = arb_idx;
          grant_d       = arb_gnt;
          dirty_d       = 1'b0;
          snoop_valid_d = 1'b1;
          snoop_write_d = req_write[arb_idx];
          snoop_tag_d   = tag_arr[arb_idx];
          snoop_src_d   = arb_gnt;
          state_d       = BCAST;
        end
      end
      BCAST: begin
        cnt_d   = CNT_W'(SNOOP_CYCLES);
        state_d = SNOOP;
      end
      SNOOP: begin
        // On a write the owner just invalidates; its data is never used.
        if (snoop_dirty && !dirty_q && !req_q.write) begin
          dirty_d = 1'b1;
          sdata_d = snoop_data;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d   = MEM;
          mem_tag_d = req_q.tag;
          if (req_q.write)  mem_bus_d = mem_write_word(req_q.data);
          else if (dirty_d) mem_bus_d = mem_write_word(sdata_d);
          else              mem_bus_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEM: begin
        mem_bus_d           = '0;
        resp_valid_d[idx_q] = 1'b1;
        if (req_q.write)  resp_data_d = req_q.data;
        else if (dirty_q) resp_data_d = sdata_q;
        else              resp_data_d = mem_bus_in[DATA_W-1:0];
        state_d             = RESP;
      end
      RESP: begin
        grant_d = '0;
`ifdef FIXED_PRIORITY_EN
        rr_d    = '0;
`else
        rr_d    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      req_q         <= '0;
      idx_q         <= '0;
      rr_q          <= '0;
      cnt_q         <= '0;
      dirty_q       <= 1'b0;
      sdata_q       <= '0;
      grant_q       <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      snoop_valid_q <= 1'b0;
      snoop_write_q <= 1'b0;
      snoop_tag_q   <= '0;
      snoop_src_q   <= '0;
      mem_tag_q     <= '0;
      mem_bus_q     <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      idx_q         <= idx_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      dirty_q       <= dirty_d;
      sdata_q       <= sdata_d;
      grant_q       <= grant_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      snoop_valid_q <= snoop_valid_d;
      snoop_write_q <= snoop_write_d;
      snoop_tag_q   <= snoop_tag_d;
      snoop_src_q   <= snoop_src_d;
      mem_tag_q     <= mem_tag_d;
      mem_bus_q     <= mem_bus_d;
    end
  end

  assign grant       = grant_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign snoop_valid = snoop_valid_q;
  assign snoop_write = snoop_write_q;
  assign snoop_tag   = snoop_tag_q;
  assign snoop_src   = snoop_src_q;
  assign mem_tag_out = mem_tag_q;
  assign mem_bus_out = mem_bus_q;

endmodule
